// File: rtl/ev22_regfile_pkg.sv
// ev22_regfile_pkg
//   Shared constants and helpers for the EV22 register-file write side.
//   Slot map: r0..r27 GPR, r28/r29 sampled input ports PI0/PI1,
//   r30/r31 unused (read as 0), r32/r33 output ports PO0/PO1,
//   r34 Working_Register.
package ev22_regfile_pkg;

   localparam int DATA_W    = 16;
   localparam int NUM_SLOTS = 35;
   localparam int SEL_BITS  = 6;

   localparam logic [SEL_BITS-1:0] REG_PI0 = 6'd28;
   localparam logic [SEL_BITS-1:0] REG_PI1 = 6'd29;
   localparam logic [SEL_BITS-1:0] REG_PO0 = 6'd32;
   localparam logic [SEL_BITS-1:0] REG_PO1 = 6'd33;
   localparam logic [SEL_BITS-1:0] REG_W   = 6'd34;

   // Writable destinations: the GPRs below the PI slots, both PO slots and
   // the Working_Register. PI slots, the unused pair and 35..63 are rejected.
   function automatic logic is_legal_dest(input logic [SEL_BITS-1:0] sel);
      return (sel < REG_PI0) || (sel == REG_PO0) || (sel == REG_PO1) || (sel == REG_W);
   endfunction

endpackage

// File: rtl/po_handshake.sv
// po_handshake
//   One output-port data register with a valid/ack handshake and a sticky
//   overrun flag.
//   Ports:
//     clk      system clock
//     rst      synchronous active-high reset
//     wr       legal write targeting this port this cycle
//     wr_data  data to store on wr
//     ack      consumer accepted the current value
//     data     stored port value
//     valid    data holds a value the consumer has not yet accepted
//     overrun  sticky; set when data is replaced before it was accepted
module po_handshake #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              ack,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              overrun
);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else if (wr) begin
         // A simultaneous ack consumes the old value; the new one is pending.
         data  <= wr_data;
         valid <= 1'b1;
         if (valid && !ack) overrun <= 1'b1;
      end else if (ack) begin
         // An ack with nothing pending leaves valid at 0 anyway.
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port
//   Write side of the EV22 register file. Holds GPRs r0..r27, output ports
//   r32/r33, the Working_Register r34, and samples input ports into r28/r29.
//   All 35 slots are presented as a flat bus to the read mux.
//   Build option: define EV22_PI_SYNC_EN to pass PI0_In/PI1_In through a
//   two-flop synchronizer (2-cycle PI latency instead of 1).
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     Wr_En/Sel_C/Data_C  main write port
//     Update_W/Data_W   secondary Working_Register write (Wr_En to r34 wins)
//     PI0_In/PI1_In     external input ports
//     PO0_Ack/PO1_Ack   consumer acknowledges for the output ports
//     Reg_Flat          slot k at [16k+15:16k]; slots 30/31 read 0
//     PO0_Valid/PO1_Valid  output port holds unconsumed data
//     Wr_Err            one-cycle pulse after a write to an illegal slot
//     Overrun           sticky per-port overwrite-before-ack flags
module regfile_write_port #(
   parameter int DATA_W  = 16,
   parameter int NUM_GPR = 28,
   parameter int SEL_W   = 6
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       Wr_En,
   input  logic [SEL_W-1:0]                           Sel_C,
   input  logic [DATA_W-1:0]                          Data_C,
   input  logic                                       Update_W,
   input  logic [DATA_W-1:0]                          Data_W,
   input  logic [DATA_W-1:0]                          PI0_In,
   input  logic [DATA_W-1:0]                          PI1_In,
   input  logic                                       PO0_Ack,
   input  logic                                       PO1_Ack,
   output logic [ev22_regfile_pkg::NUM_SLOTS*DATA_W-1:0] Reg_Flat,
   output logic                                       PO0_Valid,
   output logic                                       PO1_Valid,
   output logic                                       Wr_Err,
   output logic [1:0]                                 Overrun
);

   import ev22_regfile_pkg::*;

   logic [DATA_W-1:0] gpr [NUM_GPR];
   logic [DATA_W-1:0] w_reg;
   logic [DATA_W-1:0] pi0_reg, pi1_reg;
   logic [DATA_W-1:0] po0_data, po1_data;
   logic              wr_po0, wr_po1;
   logic              overrun0, overrun1;

   // GPR array, Working_Register and error pulse.
   // NOTE: the GPR array is built from flops, not a RAM macro, so clearing
   // every entry on reset is cheap and gives a known state to the read mux.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_GPR; k++) gpr[k] <= '0;
         w_reg  <= '0;
         Wr_Err <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_GPR; k++) begin
            if (Wr_En && Sel_C == SEL_W'(k)) gpr[k] <= Data_C;
         end
         if (Wr_En && Sel_C == REG_W) w_reg <= Data_C;
         else if (Update_W)           w_reg <= Data_W;
         Wr_Err <= Wr_En && !is_legal_dest(Sel_C);
      end
   end

   // Input-port sampling; r28/r29 are the last stage in both builds.
`ifdef EV22_PI_SYNC_EN
   logic [DATA_W-1:0] pi0_meta, pi1_meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         pi0_meta <= '0;
         pi1_meta <= '0;
         pi0_reg  <= '0;
         pi1_reg  <= '0;
      end else begin
         pi0_meta <= PI0_In;
         pi1_meta <= PI1_In;
         pi0_reg  <= pi0_meta;
         pi1_reg  <= pi1_meta;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         pi0_reg <= '0;
         pi1_reg <= '0;
      end else begin
         pi0_reg <= PI0_In;
         pi1_reg <= PI1_In;
      end
   end
`endif

   assign wr_po0 = Wr_En && (Sel_C == REG_PO0);
   assign wr_po1 = Wr_En && (Sel_C == REG_PO1);

   po_handshake #(.DATA_W(DATA_W)) u_po0 (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_po0),
      .wr_data (Data_C),
      .ack     (PO0_Ack),
      .data    (po0_data),
      .valid   (PO0_Valid),
      .overrun (overrun0)
   );

   po_handshake #(.DATA_W(DATA_W)) u_po1 (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_po1),
      .wr_data (Data_C),
      .ack     (PO1_Ack),
      .data    (po1_data),
      .valid   (PO1_Valid),
      .overrun (overrun1)
   );

   assign Overrun = {overrun1, overrun0};

   // Flat read bus; unused slots 30/31 stay at the default 0.
   // NOTE: the whole bus is given a default first so no bit can hold its
   // previous value, which would otherwise infer a latch.
   always_comb begin
      Reg_Flat = '0;
      for (int k = 0; k < NUM_GPR; k++) Reg_Flat[k*DATA_W +: DATA_W] = gpr[k];
      Reg_Flat[int'(REG_PI0)*DATA_W +: DATA_W] = pi0_reg;
      Reg_Flat[int'(REG_PI1)*DATA_W +: DATA_W] = pi1_reg;
      Reg_Flat[int'(REG_PO0)*DATA_W +: DATA_W] = po0_data;
      Reg_Flat[int'(REG_PO1)*DATA_W +: DATA_W] = po1_data;
      Reg_Flat[int'(REG_W)*DATA_W   +: DATA_W] = w_reg;
   end

endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port
//   Self-checking bench for regfile_write_port. A behavioural model computes
//   the expected state for each clock edge; the expectation is queued before
//   the edge and compared against the DUT after it.
//   Honours EV22_PI_SYNC_EN the same way as the design.
module tb_regfile_write_port;

   localparam int W     = 16;
   localparam int SLOTS = 35;
   localparam int FW    = SLOTS * W;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic [5:0]      sel_c;
   logic [W-1:0]    data_c;
   logic            update_w;
   logic [W-1:0]    data_w;
   logic [W-1:0]    pi0_in, pi1_in;
   logic            po0_ack, po1_ack;
   logic [FW-1:0]   reg_flat;
   logic            po0_valid, po1_valid;
   logic            wr_err;
   logic [1:0]      overrun;

   regfile_write_port dut (
      .clk       (clk),
      .rst       (rst),
      .Wr_En     (wr_en),
      .Sel_C     (sel_c),
      .Data_C    (data_c),
      .Update_W  (update_w),
      .Data_W    (data_w),
      .PI0_In    (pi0_in),
      .PI1_In    (pi1_in),
      .PO0_Ack   (po0_ack),
      .PO1_Ack   (po1_ack),
      .Reg_Flat  (reg_flat),
      .PO0_Valid (po0_valid),
      .PO1_Valid (po1_valid),
      .Wr_Err    (wr_err),
      .Overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_slot [SLOTS];
   logic [1:0]   m_valid = 2'b00;
   logic [1:0]   m_ov    = 2'b00;
   logic         m_err   = 1'b0;
   logic [W-1:0] m_meta0 = '0;
   logic [W-1:0] m_meta1 = '0;

   typedef struct {
      string         tag;
      logic [FW-1:0] flat;
      logic [1:0]    valid;
      logic          err;
      logic [1:0]    ov;
   } exp_t;

   exp_t sb [$];

   function automatic logic legal(input logic [5:0] s);
      return (s <= 6'd27) || (s >= 6'd32 && s <= 6'd34);
   endfunction

   function automatic logic [FW-1:0] model_flat();
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < SLOTS; k++) f[k*W +: W] = m_slot[k];
      return f;
   endfunction

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_step();
      logic [1:0] acks;
      acks = {po1_ack, po0_ack};
      if (rst) begin
         for (int k = 0; k < SLOTS; k++) m_slot[k] = '0;
         m_valid = 2'b00;
         m_ov    = 2'b00;
         m_err   = 1'b0;
         m_meta0 = '0;
         m_meta1 = '0;
      end else begin
         m_err = wr_en && !legal(sel_c);
         for (int i = 0; i < 2; i++) begin
            if (wr_en && sel_c == 6'(32 + i)) begin
               if (m_valid[i] && !acks[i]) m_ov[i] = 1'b1;
               m_valid[i] = 1'b1;
            end else if (acks[i]) begin
               m_valid[i] = 1'b0;
            end
         end
         if (update_w) m_slot[34] = data_w;
         if (wr_en && legal(sel_c)) m_slot[sel_c] = data_c;
`ifdef EV22_PI_SYNC_EN
         m_slot[28] = m_meta0;
         m_slot[29] = m_meta1;
         m_meta0    = pi0_in;
         m_meta1    = pi1_in;
`else
         m_slot[28] = pi0_in;
         m_slot[29] = pi1_in;
`endif
      end
   endtask

   // Queue the expectation, clock once, then compare against the DUT.
   task automatic cycle(input string tag);
      exp_t e;
      model_step();
      e.tag   = tag;
      e.flat  = model_flat();
      e.valid = m_valid;
      e.err   = m_err;
      e.ov    = m_ov;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, "/flat"},    reg_flat, e.flat);
      check({e.tag, "/valid"},   FW'({po1_valid, po0_valid}), FW'(e.valid));
      check({e.tag, "/wr_err"},  FW'(wr_err), FW'(e.err));
      check({e.tag, "/overrun"}, FW'(overrun), FW'(e.ov));
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      update_w = 1'b0;
      po0_ack  = 1'b0;
      po1_ack  = 1'b0;
   endtask

   task automatic write(input logic [5:0] s, input logic [W-1:0] d);
      wr_en  = 1'b1;
      sel_c  = s;
      data_c = d;
   endtask

   function automatic logic [FW-1:0] slot(input int k);
      return FW'(reg_flat[k*W +: W]);
   endfunction

   initial begin
      logic [FW-1:0] one_slot;
      for (int k = 0; k < SLOTS; k++) m_slot[k] = '0;
      rst = 1'b1; sel_c = '0; data_c = '0; data_w = '0;
      pi0_in = '0; pi1_in = '0;
      idle();

      cycle("reset0");
      cycle("reset1");
      check("reset_flat", reg_flat, '0);
      rst = 1'b0;

      // Single GPR write; PI0 staged early so both builds show it in step 2.
      write(6'd5, 16'hA5A5);
      pi0_in = 16'h1234;
      cycle("gpr5");
      one_slot = '0;
      one_slot[5*W +: W] = 16'hA5A5;
`ifdef EV22_PI_SYNC_EN
      check("gpr5_only", reg_flat, one_slot);
`else
      one_slot[28*W +: W] = 16'h1234;
      check("gpr5_only", reg_flat, one_slot);
`endif
      check("gpr5_err", FW'(wr_err), '0);

      // Illegal destinations: single-cycle error pulses, storage untouched.
      write(6'd28, 16'hFFFF);
      cycle("ill28");
      check("ill28_err", FW'(wr_err), FW'(1'b1));
      check("ill28_pi0", slot(28), FW'(16'h1234));
      idle();
      cycle("ill28_gap");
      check("ill28_pulse_end", FW'(wr_err), '0);
      write(6'd40, 16'hFFFF);
      cycle("ill40");
      check("ill40_err", FW'(wr_err), FW'(1'b1));
      check("ill40_slot30", slot(30), '0);
      check("ill40_slot31", slot(31), '0);
      idle();
      cycle("ill40_gap");
      check("ill40_pulse_end", FW'(wr_err), '0);

      // PO0: write, overwrite without ack, then ack.
      write(6'd32, 16'h0001);
      cycle("po0_w1");
      check("po0_valid_set", FW'(po0_valid), FW'(1'b1));
      write(6'd32, 16'h0002);
      cycle("po0_w2");
      check("po0_data2", slot(32), FW'(16'h0002));
      check("po0_overrun", FW'(overrun), FW'(2'b01));
      idle();
      po0_ack = 1'b1;
      cycle("po0_ack");
      check("po0_valid_clr", FW'(po0_valid), '0);
      idle();

      // Working_Register: Wr_En path beats Update_W, then Update_W alone.
      write(6'd34, 16'h00FF);
      update_w = 1'b1;
      data_w   = 16'hFF00;
      cycle("w_both");
      check("w_wr_wins", slot(34), FW'(16'h00FF));
      wr_en  = 1'b0;
      data_w = 16'h1357;
      cycle("w_upd");
      check("w_update", slot(34), FW'(16'h1357));
      idle();

      // PO1: write and ack in the same cycle keeps valid, no overrun.
      write(6'd33, 16'hAAAA);
      cycle("po1_w1");
      write(6'd33, 16'hBBBB);
      po1_ack = 1'b1;
      cycle("po1_w_ack");
      check("po1_valid_kept", FW'(po1_valid), FW'(1'b1));
      check("po1_data", slot(33), FW'(16'hBBBB));
      check("po1_no_overrun", FW'(overrun[1]), '0);
      wr_en = 1'b0;
      cycle("po1_ack");
      check("po1_valid_clr", FW'(po1_valid), '0);
      cycle("po1_ack_idle");
      idle();

      // PI1 step latency.
      pi1_in = 16'hBEEF;
      cycle("pi1_e1");
`ifdef EV22_PI_SYNC_EN
      check("pi1_after1", slot(29), '0);
`else
      check("pi1_after1", slot(29), FW'(16'hBEEF));
`endif
      cycle("pi1_e2");
      check("pi1_after2", slot(29), FW'(16'hBEEF));

      // Random traffic biased toward the special slots.
      for (int n = 0; n < 60; n++) begin
         wr_en    = 1'($urandom_range(0, 1));
         sel_c    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 34))
                                                : 6'($urandom_range(0, 63));
         data_c   = W'($urandom);
         update_w = 1'($urandom_range(0, 1));
         data_w   = W'($urandom);
         pi0_in   = W'($urandom);
         pi1_in   = W'($urandom);
         po0_ack  = 1'($urandom_range(0, 1));
         po1_ack  = 1'($urandom_range(0, 1));
         cycle("rand");
      end

      // Reset mid-sequence dominates a pending illegal write and acks.
      write(6'd40, 16'h5555);
      update_w = 1'b1;
      rst      = 1'b1;
      cycle("mid_rst");
      check("mid_rst_flat", reg_flat, '0);
      check("mid_rst_valid", FW'({po1_valid, po0_valid}), '0);
      check("mid_rst_err", FW'(wr_err), '0);
      check("mid_rst_overrun", FW'(overrun), '0);
      rst = 1'b0;
      idle();
      cycle("post_rst");

      check("sb_drained", FW'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
